sigma_delta_dac_sequencer: RTL and testbench
============================================

# sigma_delta_dac_sequencer

Sample-rate controller that sits between a streaming PCM source and the first-order sigma-delta DAC modulator. It buffers signed two's-complement samples in a small FIFO and releases one sample per output-rate period, derived by dividing `clk` by the oversampling ratio. Each released sample is converted to the modulator's offset-binary format. It handles priming, underrun recovery, muting with a linear ramp, and disable, so the modulator always sees a defined code.

## Interface
- `DAC_BITLEN`, 16: sample and DAC code width.
- `OSR_DIV`, 256: `clk` cycles per output sample; must be ≥ 4.
- `FIFO_DEPTH`, 4: sample buffer depth; must be a power of 2 and ≥ 2.
- `RAMP_STEP`, 256: magnitude change per sample tick while muting.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  level; 1 = run, 0 = idle and flush.
- `mute`  in  1  level; 1 = ramp output to midscale.
- `s_data`  in  `DAC_BITLEN`  signed PCM sample.
- `s_valid`  in  1  sample valid.
- `s_ready`  out  1  sample accepted when `s_valid && s_ready`.
- `dac_input`  out  `DAC_BITLEN`  offset-binary code to the modulator.
- `dac_valid`  out  1  one-cycle pulse when `dac_input` updates.
- `sample_tick`  out  1  one-cycle pulse at each output-rate boundary.
- `underrun`  out  1  one-cycle pulse when a tick finds the FIFO empty in `RUN`.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  current occupancy.

## Operation
- **Midscale and conversion.**
  - `MID` = 1 << (`DAC_BITLEN`-1).
  - Conversion is an MSB flip: `code = s_data ^ MID`. For example, 0x8000 → 0x0000, 0x0000 → 0x8000, 0x7FFF → 0xFFFF.
- **FSM states:** `IDLE`, `FILL`, `RUN`, `MUTE`.
- **`IDLE`**
  - FIFO flushed, `s_ready`=0, tick counter held at 0, `dac_input`=`MID`.
  - Goes to `FILL` when `enable`=1.
- **`FILL`**
  - `s_ready` = !full. Ticks run; `dac_input` holds its last value and no pops occur.
  - Goes to `RUN` on the first tick with `fifo_level` ≥ `FIFO_DEPTH`/2. That same tick pops.
- **`RUN`**
  - Each tick pops the head sample, registers its code to `dac_input` and pulses `dac_valid`.
  - A tick with the FIFO empty holds `dac_input`, pulses `underrun` with no `dac_valid`, and goes to `FILL`.
- **`MUTE`**
  - Entered from `FILL` or `RUN` while `mute`=1; `mute` takes priority over a `FILL` → `RUN` transition.
  - Each tick pops a sample if one is present, and discards it.
  - Each tick moves `dac_input` toward `MID` by `RAMP_STEP` and saturates at `MID` without overshoot. `dac_valid` pulses on every tick.
  - Goes to `FILL` when `mute`=0; the FIFO is then re-primed before output resumes.
- **`enable`=0 in any non-`IDLE` state.** Next cycle: `IDLE`, FIFO flushed, `dac_input`=`MID`, `dac_valid` pulses once.
- **FIFO**
  - Write on `s_valid && s_ready`; `s_ready` is 0 when full.
  - Push and pop in the same cycle are legal when not full; `fifo_level` is unchanged.
  - There is no bypass: a sample written on a tick cycle is not popped by that tick.

## Timing
- **Reset values:** state `IDLE`, `dac_input`=`MID`, `dac_valid`=0, `s_ready`=0, `sample_tick`=0, `underrun`=0, `fifo_level`=0, tick counter 0.
- **Tick counter.**
  - Counts 0..`OSR_DIV`-1 in all states except `IDLE`, starting from 0 on entry to `FILL` from `IDLE`.
  - `sample_tick`=1 in the cycle the count is `OSR_DIV`-1, so ticks are exactly `OSR_DIV` cycles apart.
- **Output latency.** `dac_input` and `dac_valid` update in the cycle after `sample_tick`, with 1-cycle latency from the pop decision.
- **Control latency.** `s_ready` and `fifo_level` are registered and reflect the state after the current cycle's push/pop. `enable` and `mute` are sampled every cycle; their effect is visible the next cycle.
- **Reset mid-stream.** Returns to reset values on the next edge and discards FIFO contents.

## Structure
- **Package `sigma_delta_pkg`:**
  - `seq_state_t` enum (`IDLE`, `FILL`, `RUN`, `MUTE`).
  - Function `to_offset_binary()`.
  - Function `midscale()`, parameterised by width.
- **Sub-module `sd_sample_fifo`:** synchronous FIFO with width/depth parameters, push/pop/flush, full/empty and level outputs.
- **Top level:** FSM, tick counter and ramp logic live in `sigma_delta_dac_sequencer`.

## Test plan
Use `OSR_DIV`=8, `FIFO_DEPTH`=4, `RAMP_STEP`=0x4000 unless noted.
- **Reset/idle:** assert `rst` with `enable`=0 → `dac_input`=0x8000, `s_ready`=0, no ticks for 100 cycles.
- **Prime and stream:** `enable`=1, push 0x0000, 0x7FFF, 0x8000, 0x1234 → first `dac_valid` on the first tick with level ≥ 2. Outputs are 0x8000, 0xFFFF, 0x0000, 0x9234 on consecutive ticks, 8 cycles apart.
- **Underrun:** push 2 samples, then stop → two outputs, then `underrun` pulses on the next tick and `dac_input` holds 0x0000. After pushing 2 more, output resumes after re-prime.
- **Mute ramp:** stream constant 0x7FFF, assert `mute` → outputs 0xBFFF, 0x8000, 0x8000 on successive ticks. The FIFO keeps draining; releasing `mute` re-primes, then 0xFFFF resumes.
- **Disable mid-stream:** drop `enable` with a full FIFO → next cycle `fifo_level`=0, `dac_input`=0x8000, one `dac_valid`, `s_ready`=0.
- **Backpressure:** hold `s_valid`=1 continuously → `s_ready` drops at level 4, and exactly one sample is accepted per tick thereafter.

Source files
------------

// File: rtl/sigma_delta_pkg.sv
// sigma_delta_pkg: shared state encoding and code-format helpers for the DAC sequencer.
package sigma_delta_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN, MUTE} seq_state_t;

    // Widths up to 32 bits; callers truncate to their own code width.
    function automatic logic [31:0] midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

    function automatic logic [31:0] to_offset_binary(input logic [31:0] data, input int unsigned width);
        return data ^ midscale(width);
    endfunction

endpackage

// File: rtl/sd_sample_fifo.sv
// sd_sample_fifo: synchronous FIFO with flush, full/empty flags and occupancy.
module sd_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign level_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/sigma_delta_dac_sequencer.sv
// sigma_delta_dac_sequencer: buffers signed PCM and releases one offset-binary code
// per output-rate tick, with priming, underrun recovery, mute ramp and disable.
module sigma_delta_dac_sequencer
    import sigma_delta_pkg::*;
#(
    parameter int DAC_BITLEN = 16,
    parameter int OSR_DIV    = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int RAMP_STEP  = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          mute,
    input  logic [DAC_BITLEN-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DAC_BITLEN-1:0]         dac_input,
    output logic                          dac_valid,
    output logic                          sample_tick,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(OSR_DIV);
    localparam logic [DAC_BITLEN-1:0] MID     = DAC_BITLEN'(midscale(DAC_BITLEN));
    localparam logic [DAC_BITLEN-1:0] STEP    = DAC_BITLEN'(RAMP_STEP);
    localparam logic [CW-1:0]         CNT_MAX = CW'(OSR_DIV - 1);
    localparam logic [LW-1:0]         HALF    = LW'(FIFO_DEPTH / 2);

    seq_state_t            state_q;
    logic [CW-1:0]         cnt_q;
    logic [DAC_BITLEN-1:0] dac_q;
    logic                  dac_valid_q, underrun_q;
    logic                  tick, flush, push, pop, go_run, full, empty;
    logic [DAC_BITLEN-1:0] head, code, diff, ramp;
    logic [LW-1:0]         level;

    assign tick   = state_q != IDLE && cnt_q == CNT_MAX;
    assign flush  = state_q == IDLE || !enable;
    assign go_run = tick && state_q == FILL && !mute && level >= HALF;
    assign pop    = enable && (go_run || (tick && (state_q == RUN || state_q == MUTE) && !empty));
    assign s_ready = state_q != IDLE && !full;
    assign push   = s_valid && s_ready;
    assign code   = DAC_BITLEN'(to_offset_binary(32'(head), DAC_BITLEN));
    // Ramp lands exactly on midscale once the remaining distance is within one step.
    assign diff   = dac_q >= MID ? dac_q - MID : MID - dac_q;
    assign ramp   = diff <= STEP ? MID : dac_q > MID ? dac_q - STEP : dac_q + STEP;

    assign dac_input   = dac_q;
    assign dac_valid   = dac_valid_q;
    assign underrun    = underrun_q;
    assign sample_tick = tick;
    assign fifo_level  = level;

    sd_sample_fifo #(
        .WIDTH (DAC_BITLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (s_data),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dac_q       <= MID;
            dac_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            dac_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            cnt_q       <= (state_q == IDLE || !enable || tick) ? '0 : cnt_q + 1'b1;
            if (!enable) begin
                state_q     <= IDLE;
                dac_q       <= MID;
                dac_valid_q <= state_q != IDLE;
            end else begin
                case (state_q)
                    IDLE: state_q <= FILL;
                    FILL: begin
                        if (mute) state_q <= MUTE;
                        else if (go_run) begin
                            state_q     <= RUN;
                            dac_q       <= code;
                            dac_valid_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (tick && !empty) begin
                            dac_q       <= code;
                            dac_valid_q <= 1'b1;
                        end
                        underrun_q <= tick && empty;
                        state_q    <= mute ? MUTE : (tick && empty) ? FILL : RUN;
                    end
                    MUTE: begin
                        if (tick) begin
                            dac_q       <= ramp;
                            dac_valid_q <= 1'b1;
                        end
                        if (!mute) state_q <= FILL;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sigma_delta_dac_sequencer.sv
// tb_sigma_delta_dac_sequencer: directed plus randomized stimulus checked every cycle
// against a queue-based behavioural model of the sequencer.
module tb_sigma_delta_dac_sequencer;
    localparam int OSR   = 8;
    localparam int DEPTH = 4;
    localparam int STEP  = 16'h4000;
    localparam logic [15:0] MID = 16'h8000;

    logic        clk = 1'b0;
    logic        rst, enable, mute, s_valid;
    logic [15:0] s_data;
    logic        s_ready, dac_valid, sample_tick, underrun;
    logic [15:0] dac_input;
    logic [2:0]  fifo_level;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    logic [15:0] outs[$];

    // Behavioural model: 0 idle, 1 fill, 2 run, 3 mute
    int ms = 0;
    int mcnt = 0;
    logic [15:0] q[$];
    logic [15:0] mdac = MID;
    bit mvalid = 0;
    bit mund = 0;

    sigma_delta_dac_sequencer #(
        .DAC_BITLEN (16),
        .OSR_DIV    (OSR),
        .FIFO_DEPTH (DEPTH),
        .RAMP_STEP  (STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mute        (mute),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .dac_input   (dac_input),
        .dac_valid   (dac_valid),
        .sample_tick (sample_tick),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit tk, acc;
        int d;
        if (rst) begin
            ms = 0; mcnt = 0; q.delete(); mdac = MID; mvalid = 0; mund = 0;
            return;
        end
        tk  = ms != 0 && mcnt == OSR - 1;
        acc = s_valid && ms != 0 && q.size() < DEPTH;
        mvalid = 0;
        mund = 0;
        if (!enable) begin
            mvalid = ms != 0; ms = 0; mcnt = 0; q.delete(); mdac = MID;
            return;
        end
        mcnt = (ms == 0 || tk) ? 0 : mcnt + 1;
        case (ms)
            0: ms = 1;
            1: if (mute) ms = 3;
               else if (tk && q.size() >= DEPTH / 2) begin
                   mdac = q.pop_front() ^ MID; mvalid = 1; ms = 2;
               end
            2: begin
                if (tk && q.size() == 0) begin mund = 1; ms = 1; end
                else if (tk) begin mdac = q.pop_front() ^ MID; mvalid = 1; end
                if (mute) ms = 3;
            end
            default: begin
                if (tk) begin
                    if (q.size() > 0) void'(q.pop_front());
                    d = int'(mdac) - 32768;
                    if (d > STEP) d -= STEP;
                    else if (d < -STEP) d += STEP;
                    else d = 0;
                    mdac = 16'(d + 32768);
                    mvalid = 1;
                end
                if (!mute) ms = 1;
            end
        endcase
        if (acc) q.push_back(s_data);
    endtask

    // Compare every output against the model, advance the model, then cross one edge.
    task automatic cyc();
        chk("dac_input", dac_input, mdac);
        chk("dac_valid", dac_valid, mvalid);
        chk("sample_tick", sample_tick, ms != 0 && mcnt == OSR - 1);
        chk("underrun", underrun, mund);
        chk("fifo_level", fifo_level, q.size());
        chk("s_ready", s_ready, ms != 0 && q.size() < DEPTH);
        if (dac_valid) outs.push_back(dac_input);
        if (s_valid && s_ready) acc_cnt++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [15:0] d);
        s_valid = 1'b1;
        s_data = d;
        for (int i = 0; i < 200; i++) begin
            if (ms != 0 && q.size() < DEPTH) begin
                cyc();
                s_valid = 1'b0;
                return;
            end
            cyc();
        end
        chk("push_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int st, input int k);
        for (int i = 0; i < 400; i++) begin
            if ((st < 0 || ms == st) && mcnt == k) return;
            cyc();
        end
        chk("wait_timeout", 0, 1);
    endtask

    initial begin
        logic [15:0] exp_s[4];
        exp_s = '{16'h8000, 16'hFFFF, 16'h0000, 16'h9234};
        rst = 1'b1; enable = 1'b0; mute = 1'b0; s_valid = 1'b0; s_data = '0;
        @(posedge clk);
        #1;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (100) cyc();
        chk("idle_dac", dac_input, 16'h8000);
        chk("idle_ready", s_ready, 0);

        enable = 1'b1;
        cyc();
        outs.delete();
        push_sample(16'h0000);
        push_sample(16'h7FFF);
        push_sample(16'h8000);
        push_sample(16'h1234);
        repeat (40) cyc();
        chk("stream_count", outs.size(), 4);
        if (outs.size() == 4)
            for (int i = 0; i < 4; i++) chk("stream_code", outs[i], exp_s[i]);

        push_sample(16'h1111);
        push_sample(16'h8000);
        repeat (40) cyc();
        chk("underrun_hold", dac_input, 16'h0000);
        push_sample(16'h2222);
        push_sample(16'h3333);
        repeat (40) cyc();
        chk("reprime_out", dac_input, 16'hB333);

        s_valid = 1'b1;
        s_data = 16'h7FFF;
        repeat (40) cyc();
        wait_cnt(2, 3);
        chk("bp_level", fifo_level, 4);
        chk("bp_ready", s_ready, 0);
        acc_cnt = 0;
        repeat (32) cyc();
        chk("bp_accepts", acc_cnt, 4);

        wait_cnt(2, 2);
        mute = 1'b1;
        s_valid = 1'b0;
        outs.delete();
        repeat (24) cyc();
        chk("mute_count", outs.size(), 3);
        if (outs.size() == 3) begin
            chk("mute_r0", outs[0], 16'hBFFF);
            chk("mute_r1", outs[1], 16'h8000);
            chk("mute_r2", outs[2], 16'h8000);
        end
        repeat (16) cyc();
        chk("mute_drain", fifo_level, 0);
        wait_cnt(-1, 2);
        mute = 1'b0;
        s_valid = 1'b1;
        repeat (48) cyc();
        chk("unmute_out", dac_input, 16'hFFFF);

        wait_cnt(2, 3);
        enable = 1'b0;
        cyc();
        chk("dis_level", fifo_level, 0);
        chk("dis_dac", dac_input, 16'h8000);
        chk("dis_valid", dac_valid, 1);
        chk("dis_ready", s_ready, 0);
        cyc();
        chk("dis_valid_once", dac_valid, 0);

        enable = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data = 16'($urandom);
            if (mcnt != OSR - 1 && $urandom_range(0, 99) < 3) mute = !mute;
            if ($urandom_range(0, 199) == 0) enable = !enable;
            cyc();
        end

        enable = 1'b1;
        mute = 1'b0;
        s_valid = 1'b1;
        repeat (30) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_dac", dac_input, 16'h8000);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_valid", dac_valid, 0);
        repeat (20) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
